fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the decode/control stage. Holds the PC and issues one word request at a time to instruction memory over a valid/ready handshake. Presents each returned instruction plus its PC to decode through a one-entry output buffer with valid/ready. Accepts a PC redirect (taken branch target) from downstream and discards any stale in-flight fetch.

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one request in flight to
// instruction memory, and hands each returned word plus its PC to decode.
module fetch_unit #(
    parameter int unsigned                 ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [ADDRESS_WIDTH-1:0] imem_rsp_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [ADDRESS_WIDTH-1:0] instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc
);

    typedef enum logic {
        FETCH,
        WAIT
    } state_t;

    state_t                     state, state_nx;
    logic [ADDRESS_WIDTH-1:0]   pc, pc_nx, pc_inc, redirect_aligned;
    logic                       drop, drop_nx;
    logic                       instr_valid_nx;
    logic [ADDRESS_WIDTH-1:0]   instr_nx, instr_pc_nx;

    assign pc_inc           = pc + ADDRESS_WIDTH'(4);
    assign redirect_aligned = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    assign imem_req_addr    = pc;

    always_comb begin
        imem_req_valid = 1'b0;
        state_nx       = state;
        pc_nx          = pc;
        drop_nx        = drop;
        instr_valid_nx = instr_valid;
        instr_nx       = instr;
        instr_pc_nx    = instr_pc;

        if (instr_valid && instr_ready) begin
            instr_valid_nx = 1'b0;
        end

        case (state)
            FETCH: begin
                // Only issue when the buffer will be free by the time data returns.
                imem_req_valid = (!instr_valid || instr_ready) && !rst;
                if (imem_req_valid && imem_req_ready) begin
                    state_nx = WAIT;
                    if (redirect_valid) begin
                        drop_nx = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_nx = FETCH;
                    drop_nx  = 1'b0;
                    if (!drop && !redirect_valid) begin
                        instr_nx       = imem_rsp_data;
                        instr_pc_nx    = pc;
                        instr_valid_nx = 1'b1;
                        pc_nx          = pc_inc;
                    end
                end else if (redirect_valid) begin
                    drop_nx = 1'b1;
                end
            end
            default: begin
                state_nx = FETCH;
            end
        endcase

        // Redirect overrides any PC advance and flushes the buffer, even if
        // decode is consuming it this cycle.
        if (redirect_valid) begin
            pc_nx          = redirect_aligned;
            instr_valid_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            drop        <= drop_nx;
            instr_valid <= instr_valid_nx;
            instr       <= instr_nx;
            instr_pc    <= instr_pc_nx;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard of expected (pc, instruction)
// pairs is popped on every decode handshake; a second instance covers PC wrap.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data, instr, instr_pc, redirect_pc;
    logic        instr_valid, instr_ready, redirect_valid;

    logic        b_rst, b_req_valid, b_req_ready, b_rsp_valid;
    logic [31:0] b_req_addr, b_rsp_data, b_instr, b_instr_pc;
    logic        b_instr_valid, b_instr_ready;

    int unsigned mem_lat;
    logic        mem_ovr;
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDRESS_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.ADDRESS_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(b_rst),
        .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready),
        .imem_req_addr(b_req_addr), .imem_rsp_valid(b_rsp_valid),
        .imem_rsp_data(b_rsp_data), .instr_valid(b_instr_valid),
        .instr_ready(b_instr_ready), .instr(b_instr), .instr_pc(b_instr_pc),
        .redirect_valid(1'b0), .redirect_pc(32'h0)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory for the main instance: answers mem_lat cycles after the earliest
    // legal response cycle, optionally with a fixed poison word.
    initial begin
        logic [31:0] a;
        int unsigned lat;
        logic        ovr;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                a   = imem_req_addr;
                lat = mem_lat;
                ovr = mem_ovr;
                @(posedge clk); #1;
                repeat (lat) begin
                    @(posedge clk); #1;
                end
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ovr ? 32'hDEAD_BEEF : mem_word(a);
                @(posedge clk); #1;
                imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no $finish, expected end of directed sequence");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = mem_word(pc);
        sb.push_back(e);
    endtask

    // Mid-cycle sample point; retires a scoreboard entry on every real consume.
    task automatic half();
        exp_t e;
        @(negedge clk);
        if (instr_valid === 1'b1 && instr_ready && !redirect_valid) begin
            n_vec++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL sb_underflow: observed pc %h instr %h expected no instruction", instr_pc, instr);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_instr", instr, e.data);
            end
        end
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic step();
        half();
        next();
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; mem_lat = 0; mem_ovr = 1'b0;
        b_rst = 1'b1; b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = '0;
        b_instr_ready = 1'b0;
        next();
        next();

        // Reset state
        half();
        chk("rst_ivalid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_reqv", {31'b0, imem_req_valid}, 32'd0);
        next();

        // Zero-wait streaming: valid every second cycle, pcs 0,4,8,C
        rst = 1'b0;
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        for (int k = 0; k < 8; k++) begin
            half();
            if (k == 0) begin
                chk("first_reqv", {31'b0, imem_req_valid}, 32'd1);
                chk("first_addr", imem_req_addr, 32'h0);
            end
            chk("vld_pattern", {31'b0, instr_valid}, (k >= 2 && k % 2 == 0) ? 32'd1 : 32'd0);
            next();
        end

        // Decode stalled: buffer holds, no new request
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            half();
            chk("hold_ivalid", {31'b0, instr_valid}, 32'd1);
            chk("hold_ipc", instr_pc, 32'hC);
            chk("hold_reqv", {31'b0, imem_req_valid}, 32'd0);
            next();
        end

        // Memory back-pressure: request held stable for 3 cycles
        instr_ready = 1'b1; imem_req_ready = 1'b0;
        push(32'h10);
        for (int i = 0; i < 3; i++) begin
            half();
            chk("stall_reqv", {31'b0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_req_addr, 32'h10);
            next();
        end
        imem_req_ready = 1'b1;
        half();
        chk("acc_reqv", {31'b0, imem_req_valid}, 32'd1);
        chk("acc_addr", imem_req_addr, 32'h10);
        next();
        half();
        chk("wait_reqv", {31'b0, imem_req_valid}, 32'd0);
        next();

        // Redirect in WAIT, poisoned response two cycles later is dropped
        mem_lat = 2; mem_ovr = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        half();
        chk("rdw_reqv", {31'b0, imem_req_valid}, 32'd0);
        next();
        redirect_valid = 1'b0;
        half();
        chk("rdw_ivalid0", {31'b0, instr_valid}, 32'd0);
        next();
        half();
        chk("rdw_ivalid1", {31'b0, instr_valid}, 32'd0);
        next();
        mem_lat = 0; mem_ovr = 1'b0;
        push(32'h100);
        half();
        chk("rdw_addr", imem_req_addr, 32'h100);
        chk("rdw_reqv2", {31'b0, imem_req_valid}, 32'd1);
        chk("rdw_ivalid2", {31'b0, instr_valid}, 32'd0);
        next();
        step();
        step();

        // Redirect to unaligned target coinciding with a response
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        redirect_valid = 1'b0;
        push(32'h200);
        half();
        chk("rdr_addr", imem_req_addr, 32'h200);
        chk("rdr_ivalid", {31'b0, instr_valid}, 32'd0);
        next();
        step();
        step();
        step();

        // Redirect coinciding with FETCH acceptance while the buffer is full
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        half();
        chk("rda_ivalid_pre", {31'b0, instr_valid}, 32'd1);
        chk("rda_reqv", {31'b0, imem_req_valid}, 32'd1);
        next();
        redirect_valid = 1'b0;
        half();
        chk("rda_ivalid", {31'b0, instr_valid}, 32'd0);
        chk("rda_wait", {31'b0, imem_req_valid}, 32'd0);
        next();
        push(32'h200);
        half();
        chk("rda_addr", imem_req_addr, 32'h200);
        chk("rda_ivalid2", {31'b0, instr_valid}, 32'd0);
        next();
        step();

        // Reset while WAIT; late response lands in FETCH and is ignored
        mem_lat = 1;
        step();
        mem_lat = 0;
        rst = 1'b1;
        half();
        chk("rstw_reqv", {31'b0, imem_req_valid}, 32'd0);
        next();
        rst = 1'b0; imem_req_ready = 1'b0;
        half();
        chk("rstw_ivalid", {31'b0, instr_valid}, 32'd0);
        chk("rstw_addr", imem_req_addr, 32'h0);
        chk("rstw_reqv", {31'b0, imem_req_valid}, 32'd1);
        next();
        half();
        chk("ign_ivalid", {31'b0, instr_valid}, 32'd0);
        next();
        imem_req_ready = 1'b1;
        push(32'h0);
        step();
        step();
        imem_req_ready = 1'b0;
        step();

        // PC wrap from FFFF_FFFC on the second instance
        b_rst = 1'b0; b_req_ready = 1'b1;
        half();
        chk("wrap_addr0", b_req_addr, 32'hFFFF_FFFC);
        chk("wrap_reqv0", {31'b0, b_req_valid}, 32'd1);
        next();
        b_rsp_valid = 1'b1; b_rsp_data = 32'h1234_5678;
        half();
        chk("wrap_wait", {31'b0, b_req_valid}, 32'd0);
        next();
        b_rsp_valid = 1'b0; b_instr_ready = 1'b1;
        half();
        chk("wrap_ivalid", {31'b0, b_instr_valid}, 32'd1);
        chk("wrap_ipc", b_instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", b_instr, 32'h1234_5678);
        chk("wrap_addr1", b_req_addr, 32'h0000_0000);
        chk("wrap_reqv1", {31'b0, b_req_valid}, 32'd1);
        next();

        chk("sb_left", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
